m_alu_mc: RTL
=============

M_ALU_MC -- requirements
Module: m_alu_mc

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/accumulator/shift width in bits (>=4, power of two).
REQ-002 SHALL derive SHW = clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port: clk  input  1  clock, rising edge.
REQ-004 SHALL have port: reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: op  input  3  opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 LSH, 111 RSH).
REQ-006 SHALL have port: data  input  WIDTH  operand.
REQ-007 SHALL have port: in_valid  input  1  request valid.
REQ-008 SHALL have port: in_ready  output  1  block can accept a request.
REQ-009 SHALL have port: acc  output  WIDTH  accumulator / quotient.
REQ-010 SHALL have port: shift  output  WIDTH  shift result / remainder.
REQ-011 SHALL have port: out_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports: zero, carry, dz  output  1 each  result-zero, carry/borrow/overflow, divide-by-zero.

Function
REQ-013 Request SHALL be accepted on a rising edge with in_valid && in_ready; op/data latched there; later input changes have no effect on that op.
REQ-014 FSM states SHALL be IDLE, MUL, DIV; in_ready = (state == IDLE), combinational.
REQ-015 ADD/SUB/AND/OR/LSH/RSH SHALL complete at the accepting edge; out_valid high the following cycle; back-to-back accepts every cycle allowed.
REQ-016 ADD: acc <= (acc+data) mod 2^WIDTH, carry <= carry-out; SUB: acc <= (acc-data) mod 2^WIDTH, carry <= (acc < data).
REQ-017 AND/OR: acc <= acc & data / acc | data; carry <= 0.
REQ-018 LSH/RSH: shift <= acc shifted left/right logically by data[SHW-1:0]; acc unchanged; carry <= last bit shifted out, 0 if amount 0.
REQ-019 MUL: shift-add over exactly WIDTH cycles in state MUL; completion edge is WIDTH edges after accept; acc <= low WIDTH bits of product; carry <= (high half != 0).
REQ-020 DIV (data != 0): unsigned restoring division over exactly WIDTH cycles in state DIV; acc <= quotient, shift <= remainder; carry <= 0.
REQ-021 DIV by 0: no iteration, single-cycle completion; acc <= all ones, shift <= old acc, dz <= 1.
REQ-022 dz SHALL clear on the next accepted non-faulting op; zero SHALL reflect (acc==0) after acc-writing ops and (shift==0) after LSH/RSH.
REQ-023 in_valid while busy SHALL be ignored; acc/shift/flags SHALL hold their previous values until the completion edge; out_valid low otherwise.
REQ-024 in_ready SHALL return high in the cycle after the multi-cycle completion edge.

Reset
REQ-025 reset low SHALL immediately force acc=0, shift=0, zero=0, carry=0, dz=0, out_valid=0, state=IDLE (in_ready=1), iteration counter=0.
REQ-026 reset mid-MUL/DIV SHALL abort the op with no out_valid and no partial result visible.

Configuration
REQ-027 Macro M_ALU_MC_MULDIV_EN defined: MUL/DIV iterative datapath and MUL/DIV states SHALL be compiled in as per REQ-019..021.
REQ-028 Macro M_ALU_MC_MULDIV_EN undefined: MUL/DIV SHALL be single-cycle no-ops (acc/shift unchanged, carry<=0, dz unchanged, out_valid pulses); in_ready constantly 1; no multiplier/divider logic.

Verification (WIDTH=8, macro defined unless stated)
REQ-029 Reset; ADD 0xF0; ADD 0x20 -> acc 0x10, carry 1, zero 0, out_valid one cycle after each accept.
REQ-030 acc=0x0C, MUL 0x15 -> in_ready low 8 cycles, acc 0xFC, carry 0; then MUL 0x02 -> acc 0xF8, carry 1.
REQ-031 acc=0x64, DIV 0x07 -> after 8 cycles acc 0x0E, shift 0x02, dz 0; in_valid pulses while busy ignored.
REQ-032 acc=0x37, DIV 0x00 -> next cycle acc 0xFF, shift 0x37, dz 1; following ADD 0x01 -> acc 0x00, zero 1, carry 1, dz 0.
REQ-033 acc=0x05, SUB 0x06 -> acc 0xFF, carry 1; LSH data 0x03 -> shift 0xF8, carry 1, acc 0xFF.
REQ-034 reset low at cycle 4 of MUL -> all outputs 0, no out_valid, in_ready 1; macro undefined: MUL 0x02 on acc 0x11 -> acc 0x11, out_valid next cycle.

Source files
------------

// File: rtl/m_alu_mc.sv
// Multi-cycle accumulator ALU: single-cycle add/sub/logic/shift, iterative mul/div.
// Define M_ALU_MC_MULDIV_EN to build the shift-add multiplier and restoring divider.
module m_alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] shift,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_LSH = 3'b110;
  localparam logic [2:0] OP_RSH = 3'b111;

  logic [WIDTH-1:0] acc_q, shift_q;
  logic             zero_q, carry_q, dz_q, ov_q;
  logic             accept;
  logic [WIDTH:0]   add_w, sub_w, lsh_w, rsh_w;
  logic [SHW-1:0]   amt;

  assign amt   = data[SHW-1:0];
  assign add_w = {1'b0, acc_q} + {1'b0, data};
  assign sub_w = {1'b0, acc_q} - {1'b0, data};
  // Extra bit catches the last bit shifted out; zero for amount 0.
  assign lsh_w = {1'b0, acc_q} << amt;
  assign rsh_w = {acc_q, 1'b0} >> amt;

`ifdef M_ALU_MC_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] wa_q, wb_q, wm_q;
  logic [WIDTH-1:0] mul_add, step_a, step_b;
  logic [WIDTH:0]   mul_sum, div_rs, div_df;

  assign in_ready = (state_q == IDLE);

  // wa: product high half / partial remainder; wb: multiplier / quotient.
  always_comb begin
    mul_add = wb_q[0] ? wm_q : '0;
    mul_sum = {1'b0, wa_q} + {1'b0, mul_add};
    div_rs  = {wa_q, wb_q[WIDTH-1]};
    div_df  = div_rs - {1'b0, wm_q};
    step_a  = wa_q;
    step_b  = wb_q;
    if (state_q == MUL) begin
      step_a = mul_sum[WIDTH:1];
      step_b = {mul_sum[0], wb_q[WIDTH-1:1]};
    end else if (!div_df[WIDTH]) begin
      step_a = div_df[WIDTH-1:0];
      step_b = {wb_q[WIDTH-2:0], 1'b1};
    end else begin
      step_a = div_rs[WIDTH-1:0];
      step_b = {wb_q[WIDTH-2:0], 1'b0};
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef M_ALU_MC_MULDIV_EN
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      wm_q    <= '0;
`endif
    end else begin
      ov_q <= 1'b0;
      if (accept) begin
        unique case (op)
          OP_ADD: begin
            acc_q   <= add_w[WIDTH-1:0];
            carry_q <= add_w[WIDTH];
            zero_q  <= (add_w[WIDTH-1:0] == '0);
            dz_q    <= 1'b0;
            ov_q    <= 1'b1;
          end
          OP_SUB: begin
            acc_q   <= sub_w[WIDTH-1:0];
            carry_q <= sub_w[WIDTH];
            zero_q  <= (sub_w[WIDTH-1:0] == '0);
            dz_q    <= 1'b0;
            ov_q    <= 1'b1;
          end
          OP_AND: begin
            acc_q   <= acc_q & data;
            carry_q <= 1'b0;
            zero_q  <= ((acc_q & data) == '0);
            dz_q    <= 1'b0;
            ov_q    <= 1'b1;
          end
          OP_OR: begin
            acc_q   <= acc_q | data;
            carry_q <= 1'b0;
            zero_q  <= ((acc_q | data) == '0);
            dz_q    <= 1'b0;
            ov_q    <= 1'b1;
          end
          OP_LSH: begin
            shift_q <= lsh_w[WIDTH-1:0];
            carry_q <= lsh_w[WIDTH];
            zero_q  <= (lsh_w[WIDTH-1:0] == '0);
            dz_q    <= 1'b0;
            ov_q    <= 1'b1;
          end
          OP_RSH: begin
            shift_q <= rsh_w[WIDTH:1];
            carry_q <= rsh_w[0];
            zero_q  <= (rsh_w[WIDTH:1] == '0);
            dz_q    <= 1'b0;
            ov_q    <= 1'b1;
          end
`ifdef M_ALU_MC_MULDIV_EN
          OP_MUL: begin
            state_q <= MUL;
            cnt_q   <= '0;
            wa_q    <= '0;
            wb_q    <= data;
            wm_q    <= acc_q;
          end
          OP_DIV: begin
            if (data == '0) begin
              acc_q   <= '1;
              shift_q <= acc_q;
              carry_q <= 1'b0;
              zero_q  <= 1'b0;
              dz_q    <= 1'b1;
              ov_q    <= 1'b1;
            end else begin
              state_q <= DIV;
              cnt_q   <= '0;
              wa_q    <= '0;
              wb_q    <= acc_q;
              wm_q    <= data;
            end
          end
`else
          OP_MUL, OP_DIV: begin
            carry_q <= 1'b0;
            ov_q    <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
`ifdef M_ALU_MC_MULDIV_EN
      else if (state_q != IDLE) begin
        cnt_q <= cnt_q + 1'b1;
        wa_q  <= step_a;
        wb_q  <= step_b;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          acc_q   <= step_b;
          zero_q  <= (step_b == '0);
          dz_q    <= 1'b0;
          ov_q    <= 1'b1;
          if (state_q == MUL) begin
            carry_q <= |step_a;
          end else begin
            shift_q <= step_a;
            carry_q <= 1'b0;
          end
        end
      end
`endif
    end
  end

  assign acc       = acc_q;
  assign shift     = shift_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign dz        = dz_q;
  assign out_valid = ov_q;

endmodule
